// File: rtl/display_pkg.sv
// Shared display constants: clock rate, blank pattern, driver states, hex glyphs.
// Pure definitions, no latency, no backpressure.
package display_pkg;

   localparam int CLOCK_FREQ = 100_000_000;

   // Active-low {g,f,e,d,c,b,a}; all ones turns every segment off.
   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } drv_state_t;

   // Glyph table indexed by nibble: entry 15 (F) first, entry 0 last.
   localparam logic [15:0][6:0] SEG_HEX = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg_decoder.sv
// Nibble to active-low 7-segment glyph (0-9, A, b, C, d, E, F).
// Purely combinational, no backpressure.
module seg_decoder
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seven_seg_driver.sv
// Multiplexed 4-digit 7-segment pin driver with anti-ghost blanking, frame shadows, LZB and PWM.
// Outputs registered; new digit drives BLANK_CYCLES+1 cycles after a SEL change; no backpressure.
module seven_seg_driver
   import display_pkg::*;
#(
   parameter int BLANK_CYCLES = 1000,
   parameter int PWM_BITS     = 4
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [1:0]          SEL,
   input  logic [15:0]         DIGITS,
   input  logic [3:0]          DP,
   input  logic [PWM_BITS-1:0] BRIGHTNESS,
   input  logic                LZB_EN,
   output logic [3:0]          AN,
   output logic [6:0]          SEG,
   output logic                DP_N,
   output logic                FRAME_START
);

   localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   drv_state_t          state_q, state_d;
   logic [1:0]          sel_q, sel_d;
   logic                init_q;
   logic [CNT_W-1:0]    blank_cnt_q, blank_cnt_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;

   logic [15:0]         sh_digits_q, sh_digits_d;
   logic [3:0]          sh_dp_q, sh_dp_d;
   logic [PWM_BITS-1:0] sh_bright_q, sh_bright_d;
   logic                sh_lzb_q, sh_lzb_d;

   logic                sel_change;
   logic                shadow_load;

   logic [3:0]          an_d;
   logic [6:0]          seg_d;
   logic                dp_n_d;
   logic                lit;
   logic                digit_blank;
   logic [3:0]          cur_nibble;
   logic [6:0]          dec_seg;

   // The first edge out of reset behaves exactly like a SEL change (and a frame load).
   assign sel_change  = init_q || (SEL != sel_q);
   assign shadow_load = init_q || (sel_change && (SEL == 2'd0));
   assign sel_d       = sel_change ? SEL : sel_q;

   assign sh_digits_d = shadow_load ? DIGITS     : sh_digits_q;
   assign sh_dp_d     = shadow_load ? DP         : sh_dp_q;
   assign sh_bright_d = shadow_load ? BRIGHTNESS : sh_bright_q;
   assign sh_lzb_d    = shadow_load ? LZB_EN     : sh_lzb_q;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= BLANK;
         sel_q       <= 2'd0;
         init_q      <= 1'b1;
         blank_cnt_q <= '0;
         pwm_q       <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         init_q      <= 1'b0;
         blank_cnt_q <= blank_cnt_d;
         pwm_q       <= pwm_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      blank_cnt_d = blank_cnt_q;
      if (sel_change) begin
         state_d     = BLANK;
         blank_cnt_d = '0;
      end else begin
         case (state_q)
            BLANK: begin
               if (blank_cnt_q == BLANK_LAST) begin
                  state_d     = DRIVE;
                  blank_cnt_d = '0;
               end else begin
                  blank_cnt_d = blank_cnt_q + 1'b1;
               end
            end
            DRIVE:   state_d = DRIVE;
            default: state_d = BLANK;
         endcase
      end
   end

   // PWM phase restarts at zero on the first DRIVE cycle of each digit.
   assign pwm_d = ((state_q == DRIVE) && (state_d == DRIVE)) ? pwm_q + 1'b1 : '0;

   assign cur_nibble = sh_digits_d[{sel_d, 2'b00} +: 4];

   seg_decoder u_seg_decoder (
      .nibble (cur_nibble),
      .seg    (dec_seg)
   );

   // Output logic, evaluated on next-cycle values so the pins line up with the state.
   always_comb begin
      an_d        = 4'hF;
      seg_d       = SEG_OFF;
      dp_n_d      = 1'b1;
      lit         = 1'b0;
      digit_blank = 1'b0;
      if (state_d == DRIVE) begin
         an_d[sel_d] = 1'b0;
         lit         = (pwm_d < sh_bright_d);
         case (sel_d)
            2'd1:    digit_blank = sh_lzb_d && (sh_digits_d[15:4]  == 12'h000);
            2'd2:    digit_blank = sh_lzb_d && (sh_digits_d[15:8]  == 8'h00);
            2'd3:    digit_blank = sh_lzb_d && (sh_digits_d[15:12] == 4'h0);
            default: digit_blank = 1'b0;
         endcase
         if (lit) begin
            seg_d  = digit_blank ? SEG_OFF : dec_seg;
            dp_n_d = ~sh_dp_d[sel_d];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sh_digits_q <= '0;
         sh_dp_q     <= '0;
         sh_bright_q <= '0;
         sh_lzb_q    <= 1'b0;
         AN          <= 4'hF;
         SEG         <= SEG_OFF;
         DP_N        <= 1'b1;
         FRAME_START <= 1'b0;
      end else begin
         sh_digits_q <= sh_digits_d;
         sh_dp_q     <= sh_dp_d;
         sh_bright_q <= sh_bright_d;
         sh_lzb_q    <= sh_lzb_d;
         AN          <= an_d;
         SEG         <= seg_d;
         DP_N        <= dp_n_d;
         FRAME_START <= shadow_load;
      end
   end

endmodule

// File: tb/tb_seven_seg_driver.sv
// Scoreboard bench for seven_seg_driver: directed scenarios followed by randomized SEL/data traffic.
// A cycle-level reference model predicts the pins; a monitor compares on the falling edge.
module tb_seven_seg_driver;

   localparam int BC = 4;
   localparam int PB = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [1:0]    SEL = 2'd0;
   logic [15:0]   DIGITS = 16'h0;
   logic [3:0]    DP = 4'h0;
   logic [PB-1:0] BRIGHTNESS = '0;
   logic          LZB_EN = 1'b0;
   logic [3:0]    AN;
   logic [6:0]    SEG;
   logic          DP_N;
   logic          FRAME_START;

   seven_seg_driver #(.BLANK_CYCLES(BC), .PWM_BITS(PB)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .SEL         (SEL),
      .DIGITS      (DIGITS),
      .DP          (DP),
      .BRIGHTNESS  (BRIGHTNESS),
      .LZB_EN      (LZB_EN),
      .AN          (AN),
      .SEG         (SEG),
      .DP_N        (DP_N),
      .FRAME_START (FRAME_START)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp_n;
      logic       fs;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;

   // Standard active-low glyphs {g,f,e,d,c,b,a} for 0..F.
   logic [6:0] hex_tbl [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Reference model state: cycles since the last change edge plus the latched frame.
   logic          m_pend = 1'b0;
   logic [1:0]    m_sel = 2'd0;
   int            m_since = 0;
   logic [15:0]   m_dig = 16'h0;
   logic [3:0]    m_dp = 4'h0;
   logic [PB-1:0] m_bri = '0;
   logic          m_lzb = 1'b0;

   initial begin : model
      exp_t        e;
      logic        chg, load, lit, blanked;
      logic [15:0] upper;
      int          k;
      forever begin
         @(posedge CLK);
         e.an = 4'hF; e.seg = 7'h7F; e.dp_n = 1'b1; e.fs = 1'b0;
         if (RST) begin
            m_pend = 1'b1; m_sel = 2'd0; m_since = 0;
            m_dig = 16'h0; m_dp = 4'h0; m_bri = '0; m_lzb = 1'b0;
         end else begin
            chg  = m_pend || (SEL != m_sel);
            load = m_pend || (chg && (SEL == 2'd0));
            m_pend = 1'b0;
            if (load) begin
               m_dig = DIGITS; m_dp = DP; m_bri = BRIGHTNESS; m_lzb = LZB_EN;
            end
            if (chg) begin
               m_sel = SEL; m_since = 0;
            end else begin
               m_since++;
            end
            e.fs = load;
            if (m_since >= BC) begin
               k       = m_since - BC;
               lit     = (k % (1 << PB)) < int'(m_bri);
               upper   = m_dig >> (4 * m_sel);
               blanked = m_lzb && (m_sel != 2'd0) && (upper == 16'h0);
               e.an    = ~(4'b0001 << m_sel);
               e.seg   = (lit && !blanked) ? hex_tbl[upper[3:0]] : 7'h7F;
               e.dp_n  = !(lit && m_dp[m_sel]);
            end
         end
         exp_q.push_back(e);
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act === expv) passed++;
      else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("AN",          {12'h0, AN},          {12'h0, e.an});
            check("SEG",         {9'h0, SEG},          {9'h0, e.seg});
            check("DP_N",        {15'h0, DP_N},        {15'h0, e.dp_n});
            check("FRAME_START", {15'h0, FRAME_START}, {15'h0, e.fs});
         end
      end
   end

   task automatic hold(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic frame_start_seq();
      RST = 1'b0; SEL = 2'd0; DIGITS = 16'h1234; DP = 4'h0;
      BRIGHTNESS = 4'd15; LZB_EN = 1'b0;
      hold(40);
   endtask

   initial begin : stim
      RST = 1'b1;
      hold(3);
      frame_start_seq();

      // Single change, then two changes on consecutive cycles.
      SEL = 2'd1; hold(12);
      SEL = 2'd0; hold(12);
      SEL = 2'd1; hold(1);
      SEL = 2'd2; hold(20);

      // Leading-zero blanking with 0050 and 0000.
      DIGITS = 16'h0050; LZB_EN = 1'b1; DP = 4'b1010;
      for (int v = 0; v < 2; v++) begin
         for (int s = 0; s < 4; s++) begin
            SEL = 2'(s); hold(12);
         end
         DIGITS = 16'h0000;
      end

      // Data changed mid-frame must wait for the next return to digit 0.
      DIGITS = 16'h0050; SEL = 2'd0; hold(10);
      SEL = 2'd2; hold(8);
      DIGITS = 16'hABCD; LZB_EN = 1'b0; hold(8);
      SEL = 2'd3; hold(10);
      SEL = 2'd0; hold(20);

      // Brightness extremes.
      BRIGHTNESS = 4'd0; SEL = 2'd1; hold(6);
      SEL = 2'd0; hold(30);
      BRIGHTNESS = 4'd4; SEL = 2'd1; hold(6);
      SEL = 2'd0; hold(45);

      // Reset in the middle of DRIVE, then the power-up sequence again.
      RST = 1'b1; hold(1);
      frame_start_seq();

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            RST = 1'b1; hold(1 + $urandom_range(0, 2)); RST = 1'b0;
         end
         SEL    = 2'($urandom_range(0, 3));
         DIGITS = 16'($urandom);
         if ($urandom_range(0, 2) == 0) DIGITS = DIGITS >> (4 * $urandom_range(1, 3));
         DP         = 4'($urandom);
         BRIGHTNESS = PB'($urandom);
         LZB_EN     = 1'($urandom);
         hold($urandom_range(1, 24));
      end

      hold(2);
      @(negedge CLK);
      #1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/seven_seg_driver.md
# seven_seg_driver

Consumes the 2-bit digit select from `display_controller` plus four BCD/hex digits. Drives the active-low anode and cathode pins of the board's 4-digit multiplexed 7-segment display. On every digit switch it inserts an anti-ghosting blank interval, then applies per-frame shadowed data, optional leading-zero blanking and PWM brightness. It sits between the timer datapath and the top-level display pins.

## Interface
- `BLANK_CYCLES`, default 1000: dead-time cycles after each SEL change (10 µs at 100 MHz); must be ≥ 1.
- `PWM_BITS`, default 4: width of the brightness PWM counter.
- `CLK` in 1: system clock, 100 MHz.
- `RST` in 1: reset, synchronous, active-high.
- `SEL` in 2: current digit index from `display_controller`; changes at most once per cycle.
- `DIGITS` in 16: digit n is `DIGITS[4n+3:4n]`; digit 0 is rightmost.
- `DP` in 4: decimal point enable per digit, active-high.
- `BRIGHTNESS` in PWM_BITS: on-time per PWM period.
- `LZB_EN` in 1: leading-zero blanking enable.
- `AN` out 4: anode enables, active-low.
- `SEG` out 7: cathodes {g,f,e,d,c,b,a}, active-low.
- `DP_N` out 1: decimal point cathode, active-low.
- `FRAME_START` out 1: one-cycle pulse when the shadow registers load.

## Operation
- Registered `sel_q` tracks SEL. A change is any edge where SEL ≠ sel_q; on that edge `sel_q <= SEL`.
- States: BLANK and DRIVE.
  - BLANK: AN=4'b1111, SEG=7'h7F, DP_N=1; blank counter increments. After BLANK_CYCLES cycles in BLANK, go to DRIVE.
  - DRIVE: `AN[sel_q]`=0, others 1.
  - From any state, a SEL change enters BLANK with the counter cleared. A change during BLANK restarts the count.
- Shadow registers hold DIGITS, DP, BRIGHTNESS and LZB_EN.
  - They load on the first edge after RST deasserts.
  - They also load on every edge detecting a change to SEL=0.
  - FRAME_START=1 for the cycle following each load.
  - Live inputs never reach the pins directly, so a frame cannot tear.
- Decode of shadowed nibble: 0–9 as standard digits; 10–15 as A, b, C, d, E, F.
- Leading-zero blanking (shadow LZB_EN=1): digit 3 is blanked if its nibble is 0. Digit 2 is blanked if digits 3 and 2 are both 0. Digit 1 is blanked if digits 3, 2 and 1 are all 0. Digit 0 is never blanked.
  - A blanked digit drives SEG=7'h7F; its AN is still asserted, and DP_N still follows DP.
- PWM: a PWM_BITS counter resets to 0 on entering DRIVE and increments freely.
  - The digit is lit when `pwm_cnt < BRIGHTNESS_shadow`. When unlit, SEG=7'h7F and DP_N=1, with AN still asserted.
  - BRIGHTNESS=0 means always dark. BRIGHTNESS=2^PWM_BITS−1 gives (2^PWM_BITS−1)/2^PWM_BITS duty.

## Timing
- All outputs are registered.
- Reset values: AN=4'b1111, SEG=7'h7F, DP_N=1, FRAME_START=0. State=BLANK, blank counter=0, sel_q=0, shadows=0.
- Reset mid-operation: on the next edge with RST=1, all of the above values are restored, regardless of state.
- Cycle 0 is the first cycle SEL shows a new value.
  - The edge ending cycle 0 detects the change.
  - AN=1111 from cycle 1 through cycle BLANK_CYCLES.
  - The new digit drives from cycle BLANK_CYCLES+1.
- Same timing after reset: the first edge with RST=0 acts as the change edge.
- Shadow load on the change-to-0 edge. Data is used from the first DRIVE cycle of digit 0 and held until the next change to 0.
- PWM period is 2^PWM_BITS cycles, phase-aligned to DRIVE entry.
- Two SEL changes in consecutive cycles give two restarts. The display stays blank until BLANK_CYCLES after the last change.

## Structure
- Shared package `display_pkg` holds:
  - `CLOCK_FREQ`.
  - `SEG_OFF` (7'h7F).
  - State enum `drv_state_t` {BLANK, DRIVE}.
  - The hex-to-segment constants.
- Combinational sub-module `seg_decoder` maps 4-bit nibble to 7-bit active-low segments.
- The top holds the FSM, counters, shadows, LZB and PWM gating.

## Test plan
(All with BLANK_CYCLES=4, PWM_BITS=4.)
- Reset then SEL=0, DIGITS=16'h1234, DP=0, BRIGHTNESS=15, LZB_EN=0 -> FRAME_START pulses in cycle 1; AN=1111 for 4 cycles; then AN=1110, SEG=7'b0011001 ('4'). In DRIVE, SEG is lit 15 of every 16 cycles.
- SEL 0→1 -> AN=1111 for cycles 1–4; AN=1101, SEG=7'b0110000 ('3') from cycle 5. SEL 1→2 one cycle later restarts the blank: 4 blank cycles after the second change.
- DIGITS=16'h0050, LZB_EN=1, cycle SEL 0..3 -> digits 3 and 2 show SEG=7'h7F with AN asserted. Digit 1 shows '5', digit 0 shows '0'. Digits 16'h0000 show only digit 0 as '0'.
- DIGITS changed to 16'hABCD while SEL=2 -> display keeps old data until SEL returns to 0. FRAME_START pulses then, and digit 0 shows 'd' (7'b0100001).
- BRIGHTNESS=0 -> SEG=7'h7F and DP_N=1 throughout DRIVE. BRIGHTNESS=4 -> lit exactly the first 4 of every 16 DRIVE cycles.
- RST asserted mid-DRIVE -> next edge gives AN=1111, SEG=7'h7F, DP_N=1, FRAME_START=0. After release, the same sequence as scenario 1 follows.
